bank_biu_linefill: RTL
======================

Name: bank_biu_linefill

Overview:
Receive side of the bank's linefill path. Accepts read-data beats from the bus read channel and assembles them per ID into a linefill buffer. The buffer holds one 256-bit line per set/way index (ID). On line completion it pulses biu_isu_rvalid_o/biu_isu_rid_o to the issue queue, which then reads the line combinationally through iq_linefill_buffer_raddr_i.

Parameters:
ID_WIDTH, 6, read ID width; equals set_way_offset[6:1]; buffer depth = 2**ID_WIDTH.
BEAT_WIDTH, 64, bus read-data width per beat.
LINE_WIDTH, 256, linefill line width; BEATS = LINE_WIDTH/BEAT_WIDTH (4); must be a power of 2.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
alloc_valid_i  in  1  miss path opens a linefill for alloc_id_i
alloc_id_i  in  ID_WIDTH  set/way index of the new linefill
bus_rvalid_i  in  1  read beat valid
bus_rready_o  out  1  read beat ready
bus_rid_i  in  ID_WIDTH  beat ID
bus_rdata_i  in  BEAT_WIDTH  beat data
bus_rresp_i  in  2  beat response; 0 = OKAY
bus_rlast_i  in  1  last beat of burst
biu_isu_rvalid_o  out  1  one-cycle pulse: line biu_isu_rid_o complete
biu_isu_rid_o  out  ID_WIDTH  completed ID
iq_linefill_buffer_raddr_i  in  ID_WIDTH  ISU read address
linefill_buffer_data_o  out  LINE_WIDTH  combinational read data
pending_o  out  2**ID_WIDTH  per-ID linefill-open vector
err_resp_o  out  1  sticky: non-OKAY rresp seen
err_proto_o  out  1  sticky: protocol violation seen

Behaviour:
- Reset (synchronous, rst_i high at posedge):
  - pending, beat counters, biu_isu_rvalid_o, err_* and bus_rready_o all clear to 0.
  - biu_isu_rid_o resets to 0.
  - Buffer data is not reset.
  - bus_rready_o goes to 1 on the first posedge with rst_i low, and stays 1 (registered).
- Beat accept: beat = bus_rvalid_i & bus_rready_o.
- Per-ID state: pending bit plus beat counter cnt[id], log2(BEATS) bits.
- Beat on a pending ID:
  - Write bus_rdata_i into line[id] bits [cnt*BEAT_WIDTH +: BEAT_WIDTH].
  - Increment cnt[id], which wraps to 0 after BEATS-1.
  - IDs may interleave freely; beats within one ID arrive in order.
- Completion is the beat where cnt[id] == BEATS-1:
  - Next cycle: biu_isu_rvalid_o = 1 and biu_isu_rid_o = id, for exactly one cycle. Latency from last beat = 1 cycle.
  - pending[id] clears on the same edge.
  - The data is readable in the pulse cycle.
  - At most one completion per cycle, because there is at most one beat per cycle.
- bus_rlast_i must equal (cnt[id] == BEATS-1). On mismatch, set err_proto_o; counting still follows cnt, not rlast.
- Beat on a non-pending ID: data dropped, err_proto_o set, no counter change.
- bus_rresp_i != 0: set err_resp_o; the data is still written and completion still signalled (error handling is at the core level).
- Alloc:
  - alloc_valid_i sets pending[alloc_id_i] and cnt[alloc_id_i] = 0.
  - Alloc of an already-pending ID that is not completing this cycle: ignored, err_proto_o set.
  - Alloc of an ID whose final beat arrives in the same cycle: completion is processed first, then the alloc re-opens the ID (pending stays 1, cnt = 0). The notify pulse still fires next cycle.
  - Alloc and a first beat for the same ID in the same cycle: the beat counts as non-pending (error). The alloc must precede its beats by at least one cycle.
- Read port: linefill_buffer_data_o = line[iq_linefill_buffer_raddr_i], purely combinational. A write and a read of the same ID in the same cycle returns the old data.
- A reset mid-burst discards all in-flight lines. Beats arriving after reset are non-pending and raise err_proto_o.

Decomposition:
- Shared package bank_pkg holds:
  - BIU_ID_WIDTH = 6, BIU_BEAT_WIDTH = 64, LINE_WIDTH = 256.
  - Response codes RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
- One natural sub-module: bank_linefill_ram. It is a 2**ID_WIDTH x LINE_WIDTH array with a beat-granular write enable (id, beat index, data) and an asynchronous full-line read.
- Control (pending, counters, notify, errors) stays in the top.

Test Plan:
- alloc id 0x05; beats D0..D3 = 64'h0..0_A0..A3, rlast on D3 -> pulse rvalid with rid 0x05 one cycle after D3; raddr 0x05 reads {A3,A2,A1,A0}; pending_o[5] = 0.
- alloc 0x01 and 0x3F; beats interleaved 01,3F,01,3F... -> two pulses, in the order their last beats arrived; each line assembled correctly.
- Beat with rid 0x10 never allocated -> err_proto_o = 1, no pulse, line[0x10] unchanged.
- alloc 0x02; rlast asserted on beat 2 -> err_proto_o = 1; completion still occurs only on beat 4.
- Final beat for 0x07 plus alloc 0x07 in the same cycle -> pulse rid 0x07 next cycle; pending_o[7] stays 1; a new burst on 0x07 completes normally.
- rresp = 2'b10 on one beat -> err_resp_o sticky = 1, line still completes; rst_i high mid-burst -> all outputs 0; post-reset stray beat sets err_proto_o.

Source files
------------

// File: rtl/bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bank_pkg
// Description : Shared widths and bus response codes for the bank BIU.
// Revision    : 1.0 - initial release
// ============================================================================
package bank_pkg;

    localparam int BIU_ID_WIDTH   = 6;
    localparam int BIU_BEAT_WIDTH = 64;
    localparam int LINE_WIDTH     = 256;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage : bank_pkg
`default_nettype wire

// File: rtl/bank_linefill_ram.sv
`default_nettype none
// ============================================================================
// Module      : bank_linefill_ram
// Description : Linefill buffer storage, one line per ID. Writes land one beat
//               at a time; the full line is read asynchronously.
// Revision    : 1.0 - initial release
// ============================================================================
module bank_linefill_ram #(
    parameter int ID_WIDTH   = 6,
    parameter int BEAT_WIDTH = 64,
    parameter int LINE_WIDTH = 256,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ID_WIDTH-1:0]   waddr_i,
    input  logic [CNT_WIDTH-1:0]  wbeat_i,
    input  logic [BEAT_WIDTH-1:0] wdata_i,
    input  logic [ID_WIDTH-1:0]   raddr_i,
    output logic [LINE_WIDTH-1:0] rdata_o
);
    import bank_pkg::*;

    localparam int c_DEPTH = 2**ID_WIDTH;

    // Line contents are deliberately not reset; pending state guards validity.
    logic [LINE_WIDTH-1:0] r_mem [c_DEPTH];

    // Beat-granular write: only the addressed 64-bit slice of the line changes.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i][wbeat_i*BEAT_WIDTH +: BEAT_WIDTH] <= wdata_i;
        end
    end

    // Same-cycle write/read of one ID returns the pre-write line.
    assign rdata_o = r_mem[raddr_i];

endmodule : bank_linefill_ram
`default_nettype wire

// File: rtl/bank_biu_linefill.sv
`default_nettype none
// ============================================================================
// Module      : bank_biu_linefill
// Description : Linefill receive path. Assembles bus read beats per ID into
//               the linefill buffer, pulses completion to the issue queue and
//               flags response / protocol errors.
// Revision    : 1.0 - initial release
// ============================================================================
module bank_biu_linefill #(
    parameter int ID_WIDTH   = bank_pkg::BIU_ID_WIDTH,
    parameter int BEAT_WIDTH = bank_pkg::BIU_BEAT_WIDTH,
    parameter int LINE_WIDTH = bank_pkg::LINE_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    alloc_valid_i,
    input  logic [ID_WIDTH-1:0]     alloc_id_i,
    input  logic                    bus_rvalid_i,
    output logic                    bus_rready_o,
    input  logic [ID_WIDTH-1:0]     bus_rid_i,
    input  logic [BEAT_WIDTH-1:0]   bus_rdata_i,
    input  logic [1:0]              bus_rresp_i,
    input  logic                    bus_rlast_i,
    output logic                    biu_isu_rvalid_o,
    output logic [ID_WIDTH-1:0]     biu_isu_rid_o,
    input  logic [ID_WIDTH-1:0]     iq_linefill_buffer_raddr_i,
    output logic [LINE_WIDTH-1:0]   linefill_buffer_data_o,
    output logic [2**ID_WIDTH-1:0]  pending_o,
    output logic                    err_resp_o,
    output logic                    err_proto_o
);
    import bank_pkg::*;

    localparam int c_DEPTH = 2**ID_WIDTH;
    localparam int c_BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int c_CNT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(c_BEATS - 1);

    logic                r_rready;
    logic [c_DEPTH-1:0]  r_pending;
    logic [c_CNT_W-1:0]  r_cnt [c_DEPTH];
    logic                r_rvalid;
    logic [ID_WIDTH-1:0] r_rid;
    logic                r_err_resp;
    logic                r_err_proto;

    logic                w_beat;
    logic                w_beat_ok;
    logic                w_beat_stray;
    logic [c_CNT_W-1:0]  w_cnt;
    logic                w_at_last;
    logic                w_complete;
    logic                w_rlast_bad;
    logic                w_alloc_busy;
    logic                w_alloc_ok;
    logic                w_proto_err;
    logic                w_resp_err;

    // Beat classification. A beat on an ID allocated in this same cycle sees
    // the old (clear) pending bit and is therefore treated as stray.
    assign w_beat       = bus_rvalid_i & r_rready;
    assign w_cnt        = r_cnt[bus_rid_i];
    assign w_at_last    = (w_cnt == c_LAST_BEAT);
    assign w_beat_ok    = w_beat & r_pending[bus_rid_i];
    assign w_beat_stray = w_beat & ~r_pending[bus_rid_i];
    assign w_complete   = w_beat_ok & w_at_last;
    assign w_rlast_bad  = w_beat_ok & (bus_rlast_i != w_at_last);

    // Re-allocating an ID is legal only when its final beat retires this cycle.
    assign w_alloc_busy = alloc_valid_i & r_pending[alloc_id_i]
                        & ~(w_complete & (bus_rid_i == alloc_id_i));
    assign w_alloc_ok   = alloc_valid_i & ~w_alloc_busy;

    assign w_proto_err  = w_beat_stray | w_rlast_bad | w_alloc_busy;
    assign w_resp_err   = w_beat & (bus_rresp_i != RESP_OKAY);

    // Control state: ready, per-ID pending/counters, notify pulse, sticky errors.
    // The alloc update is placed last so it overrides a same-cycle completion.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rready    <= 1'b0;
            r_pending   <= '0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_cnt[i] <= '0;
            end
            r_rvalid    <= 1'b0;
            r_rid       <= '0;
            r_err_resp  <= 1'b0;
            r_err_proto <= 1'b0;
        end else begin
            r_rready <= 1'b1;
            r_rvalid <= w_complete;
            if (w_complete) begin
                r_rid <= bus_rid_i;
            end
            if (w_beat_ok) begin
                r_cnt[bus_rid_i] <= w_cnt + 1'b1;
                if (w_at_last) begin
                    r_pending[bus_rid_i] <= 1'b0;
                end
            end
            if (w_alloc_ok) begin
                r_pending[alloc_id_i] <= 1'b1;
                r_cnt[alloc_id_i]     <= '0;
            end
            if (w_proto_err) begin
                r_err_proto <= 1'b1;
            end
            if (w_resp_err) begin
                r_err_resp <= 1'b1;
            end
        end
    end

    bank_linefill_ram #(
        .ID_WIDTH   (ID_WIDTH),
        .BEAT_WIDTH (BEAT_WIDTH),
        .LINE_WIDTH (LINE_WIDTH),
        .CNT_WIDTH  (c_CNT_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (w_beat_ok),
        .waddr_i (bus_rid_i),
        .wbeat_i (w_cnt),
        .wdata_i (bus_rdata_i),
        .raddr_i (iq_linefill_buffer_raddr_i),
        .rdata_o (linefill_buffer_data_o)
    );

    assign bus_rready_o     = r_rready;
    assign biu_isu_rvalid_o = r_rvalid;
    assign biu_isu_rid_o    = r_rid;
    assign pending_o        = r_pending;
    assign err_resp_o       = r_err_resp;
    assign err_proto_o      = r_err_proto;

endmodule : bank_biu_linefill
`default_nettype wire
